// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states and line-level constants.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;
  localparam logic PAR_EVEN   = 1'b0;
  localparam logic PAR_ODD    = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload holding register and bit index for the transmit path.
// ser_data always presents the bit that goes on the line at the next shift.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] p_data,
  output logic                  ser_data,
  output logic                  ser_done
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] data_reg;
  logic [CNT_W-1:0]      bit_cnt;

  // The counter parks on the last index and raises ser_done instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg <= '0;
      bit_cnt  <= '0;
      ser_done <= 1'b0;
    end else if (load) begin
      data_reg <= p_data;
      bit_cnt  <= '0;
      ser_done <= 1'b0;
    end else if (shift_en) begin
      if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
        ser_done <= 1'b1;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  assign ser_data = data_reg[bit_cnt];

endmodule

// File: rtl/uart_tx_fsm_serializer.sv
// UART transmitter: start bit, LSB-first payload, optional parity, one stop bit.
// One baud clock per bit; TX_OUT and Busy come straight from flops.
module uart_tx_fsm_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  tx_state_e state;
  logic      par_en_reg;
  logic      par_bit_reg;
  logic      load;
  logic      shift_en;
  logic      ser_data;
  logic      ser_done;

  assign load     = (state == IDLE) && Data_Valid;
  assign shift_en = (state == START) || ((state == DATA) && !ser_done);

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_serializer (
    .clk      (CLK),
    .rst_n    (RST),
    .load     (load),
    .shift_en (shift_en),
    .p_data   (P_DATA),
    .ser_data (ser_data),
    .ser_done (ser_done)
  );

  // Outputs are loaded with the value of the state being entered, so each
  // bit appears on the line for exactly the cycle that follows its edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      TX_OUT      <= IDLE_LEVEL;
      Busy        <= 1'b0;
      par_en_reg  <= 1'b0;
      par_bit_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          TX_OUT <= IDLE_LEVEL;
          Busy   <= 1'b0;
          if (Data_Valid) begin
            par_en_reg  <= PAR_EN;
            par_bit_reg <= (^P_DATA) ^ (PAR_TYP == PAR_ODD);
            state       <= START;
            TX_OUT      <= START_BIT;
            Busy        <= 1'b1;
          end
        end
        START: begin
          TX_OUT <= ser_data;
          state  <= DATA;
        end
        DATA: begin
          if (ser_done) begin
            if (par_en_reg) begin
              TX_OUT <= par_bit_reg;
              state  <= PARITY;
            end else begin
              TX_OUT <= STOP_BIT;
              state  <= STOP;
            end
          end else begin
            TX_OUT <= ser_data;
          end
        end
        PARITY: begin
          TX_OUT <= STOP_BIT;
          state  <= STOP;
        end
        STOP: begin
          TX_OUT <= IDLE_LEVEL;
          Busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          TX_OUT <= IDLE_LEVEL;
          Busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fsm_serializer.sv
// Scoreboard bench for uart_tx_fsm_serializer: expected {Busy, TX_OUT} per
// cycle is queued at stimulus time and popped on each falling clock edge.
module tb_uart_tx_fsm_serializer;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       Busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0] exp_q[$];

  always #5 CLK = ~CLK;

  uart_tx_fsm_serializer #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  // Reference frame: entries are {busy, line}; parity from an explicit 1s count.
  function automatic void push_frame(input logic [7:0] d, input logic pen, input logic ptyp);
    int ones = 0;
    exp_q.push_back(2'b10);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({1'b1, d[i]});
      if (d[i]) ones++;
    end
    if (pen) begin
      if (ptyp) exp_q.push_back({1'b1, ((ones % 2) == 0)});
      else      exp_q.push_back({1'b1, ((ones % 2) == 1)});
    end
    exp_q.push_back(2'b11);
  endfunction

  task automatic test_reset();
    RST = 1'b0; Data_Valid = 1'b0; P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (2) @(negedge CLK);
    n_cmp++;
    if ({Busy, TX_OUT} !== 2'b01) begin
      n_bad++; $display("FAIL reset_in: {busy,tx}=%b expected 01", {Busy, TX_OUT});
    end
    RST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      n_cmp++;
      if ({Busy, TX_OUT} !== 2'b01) begin
        n_bad++; $display("FAIL reset_idle[%0d]: {busy,tx}=%b expected 01", i, {Busy, TX_OUT});
      end
    end
  endtask

  task automatic test_no_parity();
    logic [1:0] lit [10];
    lit = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b10, 2'b11, 2'b10, 2'b11, 2'b11};
    P_DATA = 8'hA5; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    foreach (lit[i]) exp_q.push_back(lit[i]);
    exp_q.push_back(2'b01);
    @(negedge CLK);
    Data_Valid = 1'b0;
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [1:0] e;
      if (i > 0) @(negedge CLK);
      e = exp_q.pop_front();
      n_cmp++;
      if ({Busy, TX_OUT} !== e) begin
        n_bad++; $display("FAIL nopar_a5[%0d]: {busy,tx}=%b expected %b", i, {Busy, TX_OUT}, e);
      end
    end
  endtask

  task automatic test_parity();
    logic [7:0] d [3];
    logic       t [3];
    d = '{8'hA5, 8'h07, 8'h07};
    t = '{1'b0, 1'b1, 1'b0};
    for (int f = 0; f < 3; f++) begin
      P_DATA = d[f]; PAR_EN = 1'b1; PAR_TYP = t[f]; Data_Valid = 1'b1;
      push_frame(d[f], 1'b1, t[f]);
      exp_q.push_back(2'b01);
      @(negedge CLK);
      Data_Valid = 1'b0; P_DATA = ~d[f]; PAR_TYP = ~t[f];
      for (int i = 0; exp_q.size() > 0; i++) begin
        logic [1:0] e;
        if (i > 0) @(negedge CLK);
        e = exp_q.pop_front();
        n_cmp++;
        if ({Busy, TX_OUT} !== e) begin
          n_bad++; $display("FAIL parity_f%0d[%0d]: {busy,tx}=%b expected %b", f, i, {Busy, TX_OUT}, e);
        end
      end
    end
  endtask

  task automatic test_hold_valid();
    P_DATA = 8'h5A; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    push_frame(8'h5A, 1'b0, 1'b0);
    exp_q.push_back(2'b01);
    push_frame(8'h3C, 1'b0, 1'b0);
    exp_q.push_back(2'b01);
    @(negedge CLK);
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [1:0] e;
      if (i > 0) @(negedge CLK);
      e = exp_q.pop_front();
      n_cmp++;
      if ({Busy, TX_OUT} !== e) begin
        n_bad++; $display("FAIL hold_valid[%0d]: {busy,tx}=%b expected %b", i, {Busy, TX_OUT}, e);
      end
      if (i == 3)  P_DATA = 8'h3C;
      if (i == 11) Data_Valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    P_DATA = 8'hC3; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    push_frame(8'hC3, 1'b0, 1'b0);
    @(negedge CLK);
    Data_Valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      logic [1:0] e;
      if (i > 0) @(negedge CLK);
      e = exp_q.pop_front();
      n_cmp++;
      if ({Busy, TX_OUT} !== e) begin
        n_bad++; $display("FAIL rst_mid_pre[%0d]: {busy,tx}=%b expected %b", i, {Busy, TX_OUT}, e);
      end
    end
    // Line currently carries data bit 4 (a 0 for 0xC3); reset between edges.
    #1 RST = 1'b0;
    #1;
    n_cmp++;
    if ({Busy, TX_OUT} !== 2'b01) begin
      n_bad++; $display("FAIL rst_mid_async: {busy,tx}=%b expected 01", {Busy, TX_OUT});
    end
    exp_q.delete();
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if ({Busy, TX_OUT} !== 2'b01) begin
      n_bad++; $display("FAIL rst_mid_idle: {busy,tx}=%b expected 01", {Busy, TX_OUT});
    end
    P_DATA = 8'h81; Data_Valid = 1'b1;
    push_frame(8'h81, 1'b0, 1'b0);
    exp_q.push_back(2'b01);
    @(negedge CLK);
    Data_Valid = 1'b0;
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [1:0] e;
      if (i > 0) @(negedge CLK);
      e = exp_q.pop_front();
      n_cmp++;
      if ({Busy, TX_OUT} !== e) begin
        n_bad++; $display("FAIL rst_mid_81[%0d]: {busy,tx}=%b expected %b", i, {Busy, TX_OUT}, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    P_DATA = 8'h00; PAR_EN = 1'b1; PAR_TYP = 1'b1; Data_Valid = 1'b1;
    push_frame(8'h00, 1'b1, 1'b1);
    exp_q.push_back(2'b01);
    push_frame(8'hFF, 1'b1, 1'b1);
    exp_q.push_back(2'b01);
    @(negedge CLK);
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [1:0] e;
      if (i > 0) @(negedge CLK);
      e = exp_q.pop_front();
      n_cmp++;
      if ({Busy, TX_OUT} !== e) begin
        n_bad++; $display("FAIL back_to_back[%0d]: {busy,tx}=%b expected %b", i, {Busy, TX_OUT}, e);
      end
      if (i == 0)  P_DATA = 8'hFF;
      if (i == 12) Data_Valid = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_no_parity();
    test_parity();
    test_hold_valid();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
